// File: rtl/eeprom_ctrl.sv
// eeprom_ctrl: command-level EEPROM controller in front of the I2C byte driver.
// Write commands are buffered in a byte FIFO, split at page boundaries and
// followed by a write-recovery wait per chunk. Read commands are issued as one
// single-byte random read per byte, with the address auto-incremented.
//
// Handshake semantics: a transfer happens on a rising clk edge where valid and
// ready are both high; valid never depends combinationally on ready, and once
// raised, valid and its payload are held until that transfer.
// Exceptions: o_rd_valid is a one-cycle strobe with no backpressure, and
// i_drv_wr_req / i_drv_rd_valid are single-cycle requests/strobes from the driver.
module eeprom_ctrl #(
  parameter int         P_ADDR_WIDTH = 16,
  parameter logic [6:0] P_SLAVE_ADDR = 7'h50,
  parameter int         P_PAGE_SIZE  = 32,
  parameter int         P_FIFO_DEPTH = 32,
  parameter int         P_TWR_CYCLES = 500000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_type,
  input  logic [P_ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [7:0]              i_cmd_len,
  input  logic                    i_wr_valid,
  output logic                    o_wr_ready,
  input  logic [7:0]              i_wr_data,
  output logic [7:0]              o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_rd_last,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [6:0]              o_drv_slave_addr,
  output logic [P_ADDR_WIDTH-1:0] o_drv_op_addr,
  output logic [7:0]              o_drv_op_len,
  output logic                    o_drv_op_type,
  output logic                    o_drv_op_valid,
  input  logic                    i_drv_op_ready,
  output logic [7:0]              o_drv_wr_data,
  input  logic                    i_drv_wr_req,
  input  logic [7:0]              i_drv_rd_data,
  input  logic                    i_drv_rd_valid
);

  localparam int LP_PTR_W = $clog2(P_FIFO_DEPTH);
  localparam int LP_PG_W  = $clog2(P_PAGE_SIZE);
  localparam int LP_TWR_W = (P_TWR_CYCLES > 1) ? $clog2(P_TWR_CYCLES) : 1;

  localparam logic [8:0]          LP_DEPTH9   = 9'(P_FIFO_DEPTH);
  localparam logic [8:0]          LP_PAGE9    = 9'(P_PAGE_SIZE);
  localparam logic [LP_PTR_W:0]   LP_PTR_ONE  = 1;
  localparam logic [LP_TWR_W-1:0] LP_TWR_ONE  = 1;
  localparam logic [LP_TWR_W-1:0] LP_TWR_LAST = LP_TWR_W'(P_TWR_CYCLES - 1);

  // r_state is the FSM debug view; checkers bind to it directly.
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CALC, S_ISSUE, S_WAIT, S_TWR, S_NEXT, S_DONE
  } state_t;

  state_t                    r_state;
  logic                      r_type;
  logic [P_ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]                r_remaining;
  logic [7:0]                r_load_cnt;
  logic [LP_TWR_W-1:0]       r_twr_cnt;
  logic                      r_cmd_ready;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_wr_ready;
  logic                      r_op_valid;
  logic [P_ADDR_WIDTH-1:0]   r_op_addr;
  logic [7:0]                r_op_len;
  logic                      r_op_type;

  logic [7:0]                r_mem [P_FIFO_DEPTH];
  logic [LP_PTR_W:0]         r_wr_ptr;
  logic [LP_PTR_W:0]         r_rd_ptr;
  logic [7:0]                r_drv_wr_data;
  logic                      r_underrun;

  logic [7:0]                r_rd_data;
  logic                      r_rd_valid;
  logic                      r_rd_last;

  logic                      w_clip;
  logic [7:0]                w_eff_len;
  logic [7:0]                w_load_nxt;
  logic [8:0]                w_room9;
  logic [7:0]                w_chunk;
  logic                      w_push;
  logic                      w_fifo_empty;
  logic                      w_pop;

  // Writes larger than the buffer are clipped; reads use the length as given.
  assign w_clip     = !i_cmd_type && ({1'b0, i_cmd_len} > LP_DEPTH9);
  assign w_eff_len  = w_clip ? LP_DEPTH9[7:0] : i_cmd_len;
  assign w_load_nxt = r_load_cnt + 8'd1;

  // Bytes left before the next page boundary; a full page when aligned.
  assign w_room9 = LP_PAGE9 - 9'(r_addr[LP_PG_W-1:0]);
  assign w_chunk = r_type ? 8'd1 :
                   (({1'b0, r_remaining} < w_room9) ? r_remaining : w_room9[7:0]);

  assign w_push       = i_wr_valid && r_wr_ready;
  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_pop        = i_drv_wr_req && !w_fifo_empty;

  // Command sequencing FSM: accept, load, per-chunk issue/wait/recovery, done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_type      <= 1'b0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_load_cnt  <= '0;
      r_twr_cnt   <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_op_valid  <= 1'b0;
      r_op_addr   <= '0;
      r_op_len    <= '0;
      r_op_type   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_type      <= i_cmd_type;
            r_addr      <= i_cmd_addr;
            r_remaining <= w_eff_len;
            r_load_cnt  <= '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (w_eff_len == 8'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (i_cmd_type) begin
              r_state <= S_CALC;
            end else begin
              r_state    <= S_LOAD;
              r_wr_ready <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_push) begin
            r_load_cnt <= w_load_nxt;
            if (w_load_nxt == r_remaining) begin
              r_wr_ready <= 1'b0;
              r_state    <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_op_addr  <= r_addr;
          r_op_len   <= w_chunk;
          r_op_type  <= r_type;
          r_op_valid <= 1'b1;
          r_state    <= S_ISSUE;
        end
        S_ISSUE: begin
          if (i_drv_op_ready) begin
            r_op_valid <= 1'b0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The driver re-raises ready once the whole op has finished.
          if (i_drv_op_ready) begin
            if (r_type) begin
              r_state <= S_NEXT;
            end else begin
              r_twr_cnt <= '0;
              r_state   <= S_TWR;
            end
          end
        end
        S_TWR: begin
          if (r_twr_cnt == LP_TWR_LAST) r_state <= S_NEXT;
          else r_twr_cnt <= r_twr_cnt + LP_TWR_ONE;
        end
        S_NEXT: begin
          r_addr      <= r_addr + P_ADDR_WIDTH'(r_op_len);
          r_remaining <= r_remaining - r_op_len;
          if (r_remaining == r_op_len) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_CALC;
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[LP_PTR_W-1:0]] <= i_wr_data;
  end

  // FIFO pointers, driver-side byte register and the sticky underrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_drv_wr_data <= '0;
      r_underrun    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      if (w_pop) begin
        r_rd_ptr      <= r_rd_ptr + LP_PTR_ONE;
        r_drv_wr_data <= r_mem[r_rd_ptr[LP_PTR_W-1:0]];
      end
      r_underrun <= r_underrun | (i_drv_wr_req && w_fifo_empty);
    end
  end

  // Register each read byte from the driver and flag the command's last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      if (i_drv_rd_valid && r_busy && r_type) begin
        r_rd_data  <= i_drv_rd_data;
        r_rd_valid <= 1'b1;
        r_rd_last  <= (r_remaining == 8'd1);
      end
    end
  end

  assign o_cmd_ready      = r_cmd_ready;
  assign o_wr_ready       = r_wr_ready;
  assign o_rd_data        = r_rd_data;
  assign o_rd_valid       = r_rd_valid;
  assign o_rd_last        = r_rd_last;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_drv_slave_addr = P_SLAVE_ADDR;
  assign o_drv_op_addr    = r_op_addr;
  assign o_drv_op_len     = r_op_len;
  assign o_drv_op_type    = r_op_type;
  assign o_drv_op_valid   = r_op_valid;
  assign o_drv_wr_data    = r_drv_wr_data;

endmodule

// File: tb/tb_eeprom_ctrl.sv
// tb_eeprom_ctrl: table-driven bench for eeprom_ctrl with a behavioural I2C
// driver model and scoreboard queues for ops, write bytes and read bytes.
module tb_eeprom_ctrl;

  localparam int LP_T    = 20;
  localparam int LP_PAGE = 32;
  localparam int LP_FIFO = 32;

  logic        clk;
  logic        rst_n;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_type;
  logic [15:0] i_cmd_addr;
  logic [7:0]  i_cmd_len;
  logic        i_wr_valid;
  logic        o_wr_ready;
  logic [7:0]  i_wr_data;
  logic [7:0]  o_rd_data;
  logic        o_rd_valid;
  logic        o_rd_last;
  logic        o_busy;
  logic        o_done;
  logic [6:0]  o_drv_slave_addr;
  logic [15:0] o_drv_op_addr;
  logic [7:0]  o_drv_op_len;
  logic        o_drv_op_type;
  logic        o_drv_op_valid;
  logic        i_drv_op_ready;
  logic [7:0]  o_drv_wr_data;
  logic        i_drv_wr_req;
  logic [7:0]  i_drv_rd_data;
  logic        i_drv_rd_valid;

  eeprom_ctrl #(
    .P_ADDR_WIDTH(16),
    .P_SLAVE_ADDR(7'h50),
    .P_PAGE_SIZE (LP_PAGE),
    .P_FIFO_DEPTH(LP_FIFO),
    .P_TWR_CYCLES(LP_T)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_cmd_valid     (i_cmd_valid),
    .o_cmd_ready     (o_cmd_ready),
    .i_cmd_type      (i_cmd_type),
    .i_cmd_addr      (i_cmd_addr),
    .i_cmd_len       (i_cmd_len),
    .i_wr_valid      (i_wr_valid),
    .o_wr_ready      (o_wr_ready),
    .i_wr_data       (i_wr_data),
    .o_rd_data       (o_rd_data),
    .o_rd_valid      (o_rd_valid),
    .o_rd_last       (o_rd_last),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_drv_slave_addr(o_drv_slave_addr),
    .o_drv_op_addr   (o_drv_op_addr),
    .o_drv_op_len    (o_drv_op_len),
    .o_drv_op_type   (o_drv_op_type),
    .o_drv_op_valid  (o_drv_op_valid),
    .i_drv_op_ready  (i_drv_op_ready),
    .o_drv_wr_data   (o_drv_wr_data),
    .i_drv_wr_req    (i_drv_wr_req),
    .i_drv_rd_data   (i_drv_rd_data),
    .i_drv_rd_valid  (i_drv_rd_valid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [24:0] exp_op_q[$];   // {type, addr, len}
  logic [7:0]  exp_wr_q[$];   // bytes the driver must see
  logic [8:0]  exp_rd_q[$];   // {last, data} expected on o_rd_*
  logic [7:0]  drv_rd_q[$];   // bytes the driver model returns

  int n_cmp = 0;
  int n_err = 0;
  int ops_seen = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int ready_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_rd_valid) begin
        if (exp_rd_q.size() == 0) check("rd_unexpected", 1, 0);
        else check("rd_byte", {o_rd_last, o_rd_data}, exp_rd_q.pop_front());
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver model ----------------
  logic [7:0] d_len;
  logic       d_type;
  initial begin
    i_drv_op_ready = 1'b1;
    i_drv_wr_req   = 1'b0;
    i_drv_rd_valid = 1'b0;
    i_drv_rd_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && o_drv_op_valid && i_drv_op_ready) begin
        ops_seen++;
        if (exp_op_q.size() == 0) check("op_unexpected", 1, 0);
        else check("op_fields", {o_drv_op_type, o_drv_op_addr, o_drv_op_len}, exp_op_q.pop_front());
        d_len  = o_drv_op_len;
        d_type = o_drv_op_type;
        @(negedge clk);
        i_drv_op_ready = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < int'(d_len); k++) begin
          if (!d_type) begin
            i_drv_wr_req = 1'b1;
            @(negedge clk);
            i_drv_wr_req = 1'b0;
            if (exp_wr_q.size() == 0) check("wr_unexpected", 1, 0);
            else check("drv_wr_data", o_drv_wr_data, exp_wr_q.pop_front());
          end else begin
            i_drv_rd_data  = (drv_rd_q.size() != 0) ? drv_rd_q.pop_front() : 8'hEE;
            i_drv_rd_valid = 1'b1;
            @(negedge clk);
            i_drv_rd_valid = 1'b0;
          end
          @(negedge clk);
        end
        i_drv_op_ready = 1'b1;
        ready_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic        typ;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [7:0]  base;
    int          exp_ops;
    int          exp_eff;
  } vec_t;

  vec_t vecs[11];
  int   acc_cyc;
  int   ops0;
  int   done0;

  // Builds expectations, accepts the command, and feeds write data.
  task automatic issue_cmd(input vec_t v);
    int eff, a, rem, ch, pushes;
    eff = (!v.typ && v.len > LP_FIFO) ? LP_FIFO : int'(v.len);
    a   = int'(v.addr);
    rem = eff;
    while (rem > 0) begin
      ch = v.typ ? 1 : ((rem < LP_PAGE - (a % LP_PAGE)) ? rem : LP_PAGE - (a % LP_PAGE));
      exp_op_q.push_back({v.typ, 16'(a), 8'(ch)});
      a   = (a + ch) % 65536;
      rem = rem - ch;
    end
    if (v.typ) begin
      for (int i = 0; i < eff; i++) begin
        drv_rd_q.push_back(8'(int'(v.base) + i));
        exp_rd_q.push_back({(i == eff - 1), 8'(int'(v.base) + i)});
      end
    end
    ops0  = ops_seen;
    done0 = done_cnt;
    @(negedge clk);
    check("cmd_ready_idle", o_cmd_ready, 1);
    i_cmd_valid = 1'b1;
    i_cmd_type  = v.typ;
    i_cmd_addr  = v.addr;
    i_cmd_len   = v.len;
    acc_cyc     = cyc;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    check("busy_after_accept", o_busy, 1);
    check("cmd_ready_busy", o_cmd_ready, 0);
    if (!v.typ && v.len != 0) begin
      pushes = 0;
      for (int i = 0; i < int'(v.len); i++) begin
        if (!o_wr_ready) break;
        i_wr_valid = 1'b1;
        i_wr_data  = 8'(int'(v.base) + i);
        exp_wr_q.push_back(8'(int'(v.base) + i));
        pushes++;
        @(negedge clk);
      end
      i_wr_valid = 1'b0;
      check("wr_ready_after_load", o_wr_ready, 0);
      check("push_count", pushes, eff);
    end
  endtask

  // Waits for completion (bounded) and checks counts, timing and idle state.
  task automatic finish_cmd(input vec_t v);
    for (int k = 0; k < 3000 && done_cnt == done0; k++) @(negedge clk);
    check("done_seen", (done_cnt != done0), 1);
    repeat (3) @(negedge clk);
    check("done_count", done_cnt - done0, 1);
    check("op_count", ops_seen - ops0, v.exp_ops);
    check("op_q_empty", exp_op_q.size(), 0);
    check("wr_q_empty", exp_wr_q.size(), 0);
    check("rd_q_empty", exp_rd_q.size(), 0);
    if (v.exp_eff == 0) check("done_latency_len0", done_cyc - acc_cyc, 1);
    else check("done_latency", done_cyc - ready_cyc, v.typ ? 2 : LP_T + 2);
    check("idle_ready", o_cmd_ready, 1);
    check("idle_busy", o_busy, 0);
    exp_op_q.delete();
    exp_wr_q.delete();
    exp_rd_q.delete();
    drv_rd_q.delete();
  endtask

  initial begin
    vecs[0]  = '{1'b0, 16'h0010, 8'd4,  8'hA1, 1, 4};
    vecs[1]  = '{1'b0, 16'h001C, 8'd8,  8'h30, 2, 8};
    vecs[2]  = '{1'b1, 16'h0100, 8'd3,  8'h5A, 3, 3};
    vecs[3]  = '{1'b1, 16'hFFFF, 8'd2,  8'hC0, 2, 2};
    vecs[4]  = '{1'b0, 16'h0005, 8'd40, 8'h10, 2, 32};
    vecs[5]  = '{1'b0, 16'h0123, 8'd0,  8'h00, 0, 0};
    vecs[6]  = '{1'b1, 16'h0456, 8'd0,  8'h00, 0, 0};
    vecs[7]  = '{1'b0, 16'h0040, 8'd32, 8'h70, 1, 32};
    vecs[8]  = '{1'b0, 16'hFFF0, 8'd20, 8'h00, 2, 20};
    vecs[9]  = '{1'b1, 16'h0020, 8'd1,  8'h99, 1, 1};
    vecs[10] = '{1'b1, 16'h0300, 8'd2,  8'h33, 2, 2};
    vecs[8].base = 8'($urandom_range(0, 255));

    rst_n       = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_type  = 1'b0;
    i_cmd_addr  = '0;
    i_cmd_len   = '0;
    i_wr_valid  = 1'b0;
    i_wr_data   = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", o_cmd_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_wr_ready", o_wr_ready, 0);
    check("rst_op_valid", o_drv_op_valid, 0);
    check("rst_rd_valid", o_rd_valid, 0);
    check("rst_slave_addr", o_drv_slave_addr, 7'h50);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      issue_cmd(vecs[i]);
      finish_cmd(vecs[i]);
    end

    // Reset during write recovery: everything returns to idle, no done pulse.
    begin
      vec_t w;
      int   rc, d0, o0;
      w = '{1'b0, 16'h0200, 8'd2, 8'hE0, 1, 2};
      rc = ready_cyc;
      issue_cmd(w);
      for (int k = 0; k < 500 && ready_cyc == rc; k++) @(negedge clk);
      check("twr_reached", (ready_cyc != rc), 1);
      repeat (5) @(negedge clk);
      d0 = done_cnt;
      o0 = ops_seen;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", o_busy, 0);
      check("midrst_cmd_ready", o_cmd_ready, 1);
      check("midrst_op_valid", o_drv_op_valid, 0);
      check("midrst_wr_ready", o_wr_ready, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (LP_T + 10) @(negedge clk);
      check("midrst_no_done", done_cnt - d0, 0);
      check("midrst_no_ops", ops_seen - o0, 0);
      exp_op_q.delete();
      exp_wr_q.delete();
      issue_cmd(vecs[10]);
      finish_cmd(vecs[10]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
